// File: rtl/seq_alu_arbiter.sv
// seq_alu_arbiter: round-robin sequencer sharing one registered ALU among N requesters
module seq_alu_arbiter #(
   parameter int N   = 4,
   parameter int W   = 8,
   parameter int IDW = $clog2(N)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N-1:0]     req_valid,
   output logic [N-1:0]     req_ready,
   input  logic [2*N-1:0]   req_opcode,
   input  logic [W*N-1:0]   req_a,
   input  logic [W*N-1:0]   req_b,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic [IDW-1:0]   resp_id,
   output logic [W-1:0]     resp_data,
   output logic             alu_en,
   output logic [1:0]       alu_opcode,
   output logic [W-1:0]     alu_a,
   output logic [W-1:0]     alu_b,
   input  logic [W-1:0]     alu_c,
   output logic             busy
);
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ISSUE = 2'd1;
   localparam logic [1:0] WAIT  = 2'd2;
   localparam logic [1:0] RESP  = 2'd3;
   logic [1:0]     state;
   logic [IDW-1:0] rr_ptr;
   logic [IDW-1:0] g;
   logic           found;
   // first valid requester at or after rr_ptr, wrapping upward
   always_comb begin
      g = '0;
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
         if (!found && req_valid[(int'(rr_ptr) + k) % N]) begin
            g = IDW'((int'(rr_ptr) + k) % N);
            found = 1'b1;
         end
      end
   end
   assign req_ready  = (state == IDLE && found && !rst) ? N'(1) << g : '0;
   assign alu_en     = state == ISSUE;
   assign resp_valid = state == RESP;
   assign busy       = state != IDLE;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         rr_ptr     <= '0;
         resp_id    <= '0;
         resp_data  <= '0;
         alu_opcode <= '0;
         alu_a      <= '0;
         alu_b      <= '0;
      end else begin
         case (state)
            IDLE: if (found) begin
               alu_opcode <= req_opcode[2*g +: 2];
               alu_a      <= req_a[W*g +: W];
               alu_b      <= req_b[W*g +: W];
               resp_id    <= g;
               state      <= ISSUE;
            end
            ISSUE: state <= WAIT;
            WAIT: begin
               resp_data <= alu_c;
               state     <= RESP;
            end
            default: if (resp_ready) begin
               rr_ptr <= (resp_id == IDW'(N - 1)) ? '0 : resp_id + 1'b1;
               state  <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_seq_alu_arbiter.sv
// tb_seq_alu_arbiter: randomized and directed checks of seq_alu_arbiter against a round-robin model
module tb_seq_alu_arbiter;
   localparam int N = 4;
   localparam int W = 8;
   localparam int IDW = 2;
   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [N-1:0]     req_valid = '0;
   logic [N-1:0]     req_ready;
   logic [2*N-1:0]   req_opcode;
   logic [W*N-1:0]   req_a;
   logic [W*N-1:0]   req_b;
   logic             resp_valid;
   logic             resp_ready = 1'b0;
   logic [IDW-1:0]   resp_id;
   logic [W-1:0]     resp_data;
   logic             alu_en;
   logic [1:0]       alu_opcode;
   logic [W-1:0]     alu_a;
   logic [W-1:0]     alu_b;
   logic [W-1:0]     alu_c = '0;
   logic             busy;
   logic [1:0]       op_m [N];
   logic [W-1:0]     a_m [N];
   logic [W-1:0]     b_m [N];
   int               pass_cnt = 0;
   int               total = 0;
   int               rr_model = 0;
   int               cyc = 0;
   seq_alu_arbiter #(.N(N), .W(W), .IDW(IDW)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_opcode(req_opcode), .req_a(req_a), .req_b(req_b),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
      .resp_data(resp_data), .alu_en(alu_en), .alu_opcode(alu_opcode),
      .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c), .busy(busy)
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   function automatic logic [W-1:0] alu_f(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      return op == 2'd0 ? a + b : op == 2'd1 ? a - b : op == 2'd2 ? a & b : a | b;
   endfunction
   // environment ALU: registered result, updated only when enabled
   always @(posedge clk) if (alu_en) alu_c <= alu_f(alu_opcode, alu_a, alu_b);
   always_comb begin
      for (int i = 0; i < N; i++) begin
         req_opcode[2*i +: 2] = op_m[i];
         req_a[W*i +: W] = a_m[i];
         req_b[W*i +: W] = b_m[i];
      end
   end
   function automatic int pick(input logic [N-1:0] m, input int rr);
      for (int k = 0; k < N; k++) if (m[(rr + k) % N]) return (rr + k) % N;
      return -1;
   endfunction
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) $display("FAIL %s: got %h expected %h", name, got, exp);
      else pass_cnt++;
   endtask
   task automatic rand_ops;
      for (int i = 0; i < N; i++) begin
         op_m[i] = 2'($urandom_range(0, 3));
         a_m[i] = W'($urandom);
         b_m[i] = W'($urandom);
      end
   endtask
   // one full transaction from IDLE; caller is at posedge+1
   task automatic serve(input logic [N-1:0] mask, input int stall, input bit hold, output int gc);
      int g;
      logic [W-1:0] exp;
      logic [N-1:0] oh;
      logic [IDW+W:0] snap;
      req_valid = mask;
      #1;
      g = pick(mask, rr_model);
      oh = (g < 0) ? '0 : N'(1) << g;
      gc = cyc;
      total++;
      if (req_ready !== oh) $display("FAIL grant: req_ready %b expected %b", req_ready, oh);
      else pass_cnt++;
      if (g < 0) return;
      exp = alu_f(op_m[g], a_m[g], b_m[g]);
      tick;
      req_valid[g] = hold;
      #1;
      total++;
      if ({alu_en, busy, req_ready, alu_opcode, alu_a, alu_b} !== {2'b11, 4'b0, op_m[g], a_m[g], b_m[g]})
         $display("FAIL issue: en=%b busy=%b rdy=%b op=%h a=%h b=%h expected op=%h a=%h b=%h",
                  alu_en, busy, req_ready, alu_opcode, alu_a, alu_b, op_m[g], a_m[g], b_m[g]);
      else pass_cnt++;
      tick;
      chk("wait", {alu_en, resp_valid, busy, req_ready}, {3'b001, 4'b0});
      tick;
      total++;
      if ({resp_valid, resp_id, resp_data} !== {1'b1, IDW'(g), exp})
         $display("FAIL resp: valid=%b id=%0d data=%h expected id=%0d data=%h", resp_valid, resp_id, resp_data, g, exp);
      else pass_cnt++;
      snap = {resp_valid, resp_id, resp_data};
      for (int s = 0; s < stall; s++) begin
         tick;
         chk("stall", {resp_valid, resp_id, resp_data, req_ready, alu_en}, {snap, 4'b0, 1'b0});
      end
      resp_ready = 1'b1;
      tick;
      resp_ready = 1'b0;
      chk("done", {resp_valid, busy}, 2'b00);
      rr_model = (g + 1) % N;
   endtask
   task automatic test_reset;
      rst = 1'b1;
      #1;
      chk("reset", {req_ready, resp_valid, resp_id, resp_data, alu_en, alu_opcode, alu_a, alu_b, busy}, '0);
      tick;
      tick;
      rst = 1'b0;
      rr_model = 0;
      chk("idle_no_req", {req_ready, busy, alu_en}, '0);
   endtask
   task automatic test_ops;
      int gc;
      op_m[0] = 2'd0; a_m[0] = 8'd5;   b_m[0] = 8'd3;
      op_m[1] = 2'd1; a_m[1] = 8'd3;   b_m[1] = 8'd5;
      op_m[2] = 2'd2; a_m[2] = 8'hF0;  b_m[2] = 8'h3C;
      op_m[3] = 2'd3; a_m[3] = 8'hF0;  b_m[3] = 8'h0F;
      serve(4'b0001, 0, 0, gc);
      chk("add_result", alu_c, 8'd8);
      serve(4'b0010, 0, 0, gc);
      chk("sub_result", alu_c, 8'hFE);
      serve(4'b0100, 0, 0, gc);
      chk("and_result", alu_c, 8'h30);
      serve(4'b1000, 0, 0, gc);
      chk("or_result", alu_c, 8'hFF);
   endtask
   task automatic test_rr_skip;
      int gc;
      serve(4'b0001, 0, 0, gc);
      chk("rr_after_0", 64'(rr_model), 64'd1);
      serve(4'b0101, 0, 1, gc);
      chk("skip_to_2", resp_id, 2'd2);
      serve(4'b0101, 0, 0, gc);
      chk("then_0", resp_id, 2'd0);
      req_valid = '0;
   endtask
   task automatic test_stall;
      int gc;
      rand_ops();
      serve(4'b1111, 5, 1, gc);
      req_valid = '0;
   endtask
   task automatic test_back_to_back;
      int gc;
      int prev;
      rand_ops();
      serve(4'b1111, 0, 1, prev);
      for (int k = 0; k < 5; k++) begin
         serve(4'b1111, 0, 1, gc);
         chk("b2b_gap", 64'(gc - prev), 64'd4);
         prev = gc;
      end
      req_valid = '0;
      tick;
   endtask
   task automatic test_reset_midflight;
      int gc;
      rand_ops();
      req_valid = 4'b0100;
      tick;
      req_valid = '0;
      tick;
      chk("in_wait", {busy, alu_en, resp_valid}, 3'b100);
      rst = 1'b1;
      #1;
      chk("async_reset", {req_ready, resp_valid, resp_id, resp_data, alu_en, alu_opcode, alu_a, alu_b, busy}, '0);
      tick;
      rst = 1'b0;
      rr_model = 0;
      for (int i = 0; i < 4; i++) begin
         tick;
         chk("no_dropped_resp", {resp_valid, busy}, 2'b00);
      end
      serve(4'b1010, 0, 0, gc);
      chk("post_reset_grant", resp_id, 2'd1);
      req_valid = '0;
   endtask
   task automatic test_random;
      int gc;
      for (int it = 0; it < 25; it++) begin
         rand_ops();
         serve(N'($urandom), $urandom_range(0, 3), 1'($urandom), gc);
         req_valid = '0;
         tick;
      end
   endtask
   initial begin
      for (int i = 0; i < N; i++) begin
         op_m[i] = '0;
         a_m[i] = '0;
         b_m[i] = '0;
      end
      test_reset();
      test_ops();
      test_rr_skip();
      test_stall();
      test_back_to_back();
      test_reset_midflight();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end
endmodule
